button_debouncer: RTL and testbench

Debounces the raw board push-buttons and produces the level (`DPBs`) and single-clock-enable pulse (`SCENs`) vectors consumed by the game-logic block for menu navigation and player movement. Each button has an independent synchronizer, a debounce counter and a 5-state FSM. An optional auto-repeat feature re-fires `SCENs` while a button is held.

---
 rtl/button_debouncer_pkg.sv | 34 +++
 rtl/button_debouncer_if.sv | 34 +++
 rtl/button_debouncer_debounce_core.sv | 164 ++++++++++++++++
 rtl/button_debouncer.sv | 48 ++++
 tb/tb_button_debouncer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/button_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the push-button debouncer: one-hot
//               FSM state encodings and default timing constants.
//               Contents:
//                 c_DEFAULT_DEBOUNCE_CYCLES - stable time before a level is
//                                             accepted (2.5 ms @ 100 MHz)
//                 c_DEFAULT_REPEAT_CYCLES   - auto-repeat period (0.5 s)
//                 c_ST_*                    - 5-bit one-hot state codes
//                 state_t                   - FSM state type
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int c_DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int c_DEFAULT_REPEAT_CYCLES   = 50000000;

    localparam logic [4:0] c_ST_IDLE         = 5'b00001;
    localparam logic [4:0] c_ST_WAIT_PRESS   = 5'b00010;
    localparam logic [4:0] c_ST_PULSE        = 5'b00100;
    localparam logic [4:0] c_ST_HELD         = 5'b01000;
    localparam logic [4:0] c_ST_WAIT_RELEASE = 5'b10000;

    typedef enum logic [4:0] {
        S_IDLE         = c_ST_IDLE,
        S_WAIT_PRESS   = c_ST_WAIT_PRESS,
        S_PULSE        = c_ST_PULSE,
        S_HELD         = c_ST_HELD,
        S_WAIT_RELEASE = c_ST_WAIT_RELEASE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/button_debouncer_if.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer_if
// Description : Button bundle between the board pins / game logic and the
//               debouncer.
//               btn_raw - raw, asynchronous, bouncy button levels
//               DPBs    - debounced levels
//               SCENs   - single-cycle press enables
//               master : drives btn_raw, observes DPBs/SCENs
//               slave  : the debouncer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface button_debouncer_if #(
    parameter int NUM_BTN = 4
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] DPBs;
    logic [NUM_BTN-1:0] SCENs;

    modport master (
        output btn_raw,
        input  DPBs,
        input  SCENs
    );

    modport slave (
        input  btn_raw,
        output DPBs,
        output SCENs
    );

endinterface
`default_nettype wire

// File: rtl/button_debouncer_debounce_core.sv
`default_nettype none
// ============================================================================
// Module      : debounce_core
// Description : Single-button debouncer: 2-flop synchronizer, debounce
//               counter and 5-state one-hot FSM with registered outputs.
//               Optional auto-repeat of the press enable while the button
//               stays held is compiled in when BUTTON_REPEAT_EN is defined.
//               Ports:
//                 clk       - system clock
//                 rst       - synchronous active-high reset
//                 i_btn_raw - raw asynchronous button level
//                 o_dpb     - debounced level
//                 o_scen    - one-cycle press enable (plus repeats)
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_core
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = c_DEFAULT_REPEAT_CYCLES
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_btn_raw,
    output logic      o_dpb,
    output logic      o_scen
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    if ((DEBOUNCE_CYCLES < 2) || (REPEAT_CYCLES < 2)) begin : g_param_check
        $error("debounce_core: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic               sync_meta_q, sync_meta_d;
    logic               btn_sync_q, btn_sync_d;
    state_t             state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               dpb_q, dpb_d;
    logic               scen_q, scen_d;

`ifdef BUTTON_REPEAT_EN
    localparam int                  c_RCNT_W   = $clog2(REPEAT_CYCLES);
    localparam logic [c_RCNT_W-1:0] c_RCNT_MAX = c_RCNT_W'(REPEAT_CYCLES - 1);

    logic [c_RCNT_W-1:0] rcnt_q, rcnt_d;
    logic                w_repeat_fire;
`endif

    always_comb begin
        sync_meta_d = i_btn_raw;
        btn_sync_d  = sync_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
`ifdef BUTTON_REPEAT_EN
        rcnt_d        = rcnt_q;
        w_repeat_fire = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (btn_sync_q) begin
                    state_d = S_WAIT_PRESS;
                    cnt_d   = '0;
                end
            end

            S_WAIT_PRESS: begin
                if (!btn_sync_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_CNT_MAX) begin
                    // Counter is cleared rather than allowed to wrap.
                    state_d = S_PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end

            S_PULSE: begin
                state_d = S_HELD;
`ifdef BUTTON_REPEAT_EN
                rcnt_d  = '0;
`endif
            end

            S_HELD: begin
                if (!btn_sync_q) begin
                    state_d = S_WAIT_RELEASE;
                    cnt_d   = '0;
                end
`ifdef BUTTON_REPEAT_EN
                else if (rcnt_q == c_RCNT_MAX) begin
                    w_repeat_fire = 1'b1;
                    rcnt_d        = '0;
                end else begin
                    rcnt_d = rcnt_q + c_RCNT_W'(1);
                end
`endif
            end

            S_WAIT_RELEASE: begin
                // A return to 1 here is bounce: back to HELD with no new enable.
                if (btn_sync_q) begin
                    state_d = S_HELD;
`ifdef BUTTON_REPEAT_EN
                    rcnt_d  = '0;
`endif
                end else if (cnt_q == c_CNT_MAX) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + c_CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they change on the
        // same edge that enters the state.
        dpb_d  = (state_d == S_PULSE) || (state_d == S_HELD) ||
                 (state_d == S_WAIT_RELEASE);
`ifdef BUTTON_REPEAT_EN
        scen_d = (state_d == S_PULSE) || w_repeat_fire;
`else
        scen_d = (state_d == S_PULSE);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_q <= 1'b0;
            btn_sync_q  <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dpb_q       <= 1'b0;
            scen_q      <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            rcnt_q      <= '0;
`endif
        end else begin
            sync_meta_q <= sync_meta_d;
            btn_sync_q  <= btn_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dpb_q       <= dpb_d;
            scen_q      <= scen_d;
`ifdef BUTTON_REPEAT_EN
            rcnt_q      <= rcnt_d;
`endif
        end
    end

    assign o_dpb  = dpb_q;
    assign o_scen = scen_q;

endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Debounces NUM_BTN board push-buttons into debounced levels
//               (DPBs) and single-cycle press enables (SCENs) for the game
//               logic. Each button is handled by an independent
//               debounce_core. Defining BUTTON_REPEAT_EN adds auto-repeat
//               of SCENs while a button is held.
//               Ports:
//                 clk   - system clock
//                 reset - synchronous active-high reset
//                 bus   - button_debouncer_if.slave (btn_raw in,
//                         DPBs/SCENs out)
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import game_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = c_DEFAULT_REPEAT_CYCLES
) (
    input  wire logic          clk,
    input  wire logic          reset,
    button_debouncer_if.slave  bus
);

    logic [NUM_BTN-1:0] w_dpbs;
    logic [NUM_BTN-1:0] w_scens;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce_core #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_core (
            .clk       (clk),
            .rst       (reset),
            .i_btn_raw (bus.btn_raw[g]),
            .o_dpb     (w_dpbs[g]),
            .o_scen    (w_scens[g])
        );
    end

    assign bus.DPBs  = w_dpbs;
    assign bus.SCENs = w_scens;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Self-checking bench for button_debouncer with
//               DEBOUNCE_CYCLES=4 and REPEAT_CYCLES=10. Stimulus segments
//               {btn_raw, expected DPBs, expected SCENs, cycles} are applied
//               per clock; expected values go through a scoreboard queue.
//               Expectations follow BUTTON_REPEAT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    logic clk;
    logic reset;

    button_debouncer_if #(.NUM_BTN(4)) bus ();

    button_debouncer #(
        .NUM_BTN         (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] dpb;
        logic [3:0] scen;
    } exp_t;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] dpb;
        logic [3:0] scen;
        int         n;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cycle    = 0;
    logic [3:0] prev_scens = 4'b0000;

    function automatic void add(input logic [3:0] raw, input logic [3:0] dpb,
                                input logic [3:0] scen, input int n);
        vec_t v;
        v.raw  = raw;
        v.dpb  = dpb;
        v.scen = scen;
        v.n    = n;
        vecs.push_back(v);
    endfunction

    // Press held for 'hold' cycles (>= 7), then released. Press accepted at
    // edge 7; release accepted 7 edges after the drop.
    function automatic void add_press_release(input logic [3:0] m, input int hold);
        add(m, 4'b0000, 4'b0000, 6);
        add(m, m, m, 1);
`ifdef BUTTON_REPEAT_EN
        for (int k = 8; k <= hold; k++)
            add(m, m, ((k >= 18) && (((k - 8) % 10) == 0)) ? m : 4'b0000, 1);
`else
        add(m, m, 4'b0000, hold - 7);
`endif
        add(4'b0000, m, 4'b0000, 6);
        add(4'b0000, 4'b0000, 4'b0000, 4);
    endfunction

    task automatic step(input logic [3:0] raw, input logic rst_in,
                        input logic [3:0] e_dpb, input logic [3:0] e_scen);
        exp_t e;
        exp_t got;
        bus.btn_raw = raw;
        reset       = rst_in;
        e.dpb       = e_dpb;
        e.scen      = e_scen;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cycle++;
        got = sb_q.pop_front();
        n_checks++;
        if (bus.DPBs !== got.dpb) begin
            n_fail++;
            $display("FAIL dpbs cycle %0d: got %b expected %b", cycle, bus.DPBs, got.dpb);
        end
        n_checks++;
        if (bus.SCENs !== got.scen) begin
            n_fail++;
            $display("FAIL scens cycle %0d: got %b expected %b", cycle, bus.SCENs, got.scen);
        end
        n_checks++;
        if ((bus.SCENs & prev_scens) !== 4'b0000) begin
            n_fail++;
            $display("FAIL scen_back_to_back cycle %0d: got %b after %b expected no overlap",
                     cycle, bus.SCENs, prev_scens);
        end
        prev_scens = bus.SCENs;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        // Clean press on button 0 held 40 cycles.
        add_press_release(4'b0001, 40);

        // Bounce on button 1 never reaches the debounce limit.
        add(4'b0010, 4'b0000, 4'b0000, 2);
        add(4'b0000, 4'b0000, 4'b0000, 2);
        add(4'b0010, 4'b0000, 4'b0000, 2);
        add(4'b0000, 4'b0000, 4'b0000, 6);
        // Stable press, then release glitch while held.
        add(4'b0010, 4'b0000, 4'b0000, 6);
        add(4'b0010, 4'b0010, 4'b0010, 1);
        add(4'b0010, 4'b0010, 4'b0000, 5);
        add(4'b0000, 4'b0010, 4'b0000, 2);
        add(4'b0010, 4'b0010, 4'b0000, 5);
        add(4'b0000, 4'b0010, 4'b0000, 6);
        add(4'b0000, 4'b0000, 4'b0000, 4);

        // Button 2 held 40 cycles (repeats only with the macro).
        add_press_release(4'b0100, 40);

        // Button 3: 4-cycle high is one short of acceptance.
        add(4'b1000, 4'b0000, 4'b0000, 4);
        add(4'b0000, 4'b0000, 4'b0000, 6);
        // 5-cycle high is accepted; release already pending when PULSE
        // ends, so the release is seen one edge after HELD is entered.
        add(4'b1000, 4'b0000, 4'b0000, 5);
        add(4'b0000, 4'b0000, 4'b0000, 1);
        add(4'b0000, 4'b1000, 4'b1000, 1);
        add(4'b0000, 4'b1000, 4'b0000, 5);
        add(4'b0000, 4'b0000, 4'b0000, 4);

        // All buttons together.
        add_press_release(4'b1111, 12);

        bus.btn_raw = 4'b0000;
        reset       = 1'b1;

        // Reset state.
        step(4'b0000, 1'b1, 4'b0000, 4'b0000);
        step(4'b0000, 1'b1, 4'b0000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].n; k++)
                step(vecs[i].raw, 1'b0, vecs[i].dpb, vecs[i].scen);
        end

        // Reset while button 3 is held: cleared at once, then re-debounced.
        for (int k = 0; k < 6; k++) step(4'b1000, 1'b0, 4'b0000, 4'b0000);
        step(4'b1000, 1'b0, 4'b1000, 4'b1000);
        for (int k = 0; k < 3; k++) step(4'b1000, 1'b0, 4'b1000, 4'b0000);
        step(4'b1000, 1'b1, 4'b0000, 4'b0000);
        for (int k = 0; k < 6; k++) step(4'b1000, 1'b0, 4'b0000, 4'b0000);
        step(4'b1000, 1'b0, 4'b1000, 4'b1000);
        for (int k = 0; k < 3; k++) step(4'b1000, 1'b0, 4'b1000, 4'b0000);
        for (int k = 0; k < 6; k++) step(4'b0000, 1'b0, 4'b1000, 4'b0000);
        for (int k = 0; k < 4; k++) step(4'b0000, 1'b0, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
